data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of data words.
REQ-002 Parameter ADDR_W, default 16, width of addresses.
REQ-003 Parameter MEM_DEPTH, default 256, number of valid words in DataMemory; legal addresses are 0..MEM_DEPTH-1.
REQ-004 Clock  in  1  single clock; all state changes on rising edge.
REQ-005 Reset  in  1  synchronous, active-low reset, sampled on rising edge of Clock.
REQ-006 A_Req, A_Write  in  1 each  port A (CPU) request and write(1)/read(0) select.
REQ-007 A_Addr  in  ADDR_W; A_WData  in  DATA_W  port A address and write data.
REQ-008 A_Ack  out  1; A_Err  out  1; A_RData  out  DATA_W  port A completion pulse, address error flag and read data.
REQ-009 B_Req, B_Write, B_Addr, B_WData, B_Ack, B_Err, B_RData  port B (DMA/debug), identical to port A.
REQ-010 Mem_Adresa  out  ADDR_W; Mem_WriteData  out  DATA_W; Mem_MemWrite, Mem_MemRead  out  1  drive DataMemory.
REQ-011 Mem_ReadData  in  DATA_W  DataMemory read data, combinational from Mem_Adresa while Mem_MemRead=1.
REQ-012 Busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESP, and no others.
REQ-014 In IDLE with one Req high, the arbiter SHALL grant that port, latch its Write/Addr/WData and enter ACCESS next cycle.
REQ-015 In IDLE with both Req high, the arbiter SHALL grant the port not recorded in LastGrant (round-robin) and then update LastGrant.
REQ-016 If the latched address is >= MEM_DEPTH, the arbiter SHALL go IDLE->RESP, skip ACCESS and assert no memory strobe.
REQ-017 In ACCESS, for exactly one cycle, the arbiter SHALL drive Mem_Adresa/Mem_WriteData from the latches and assert Mem_MemWrite (write) or Mem_MemRead (read).
REQ-018 During a read ACCESS cycle, Mem_ReadData SHALL be captured into the granted port's RData register at the closing edge.
REQ-019 ACCESS SHALL always go to RESP.
REQ-020 In RESP, the granted port's Ack SHALL be high for exactly one cycle, with Err=1 only for out-of-range addresses; the next state SHALL be IDLE.
REQ-021 On a read, RData SHALL be valid in the Ack cycle and held until that port's next completion.
REQ-022 On a write or an error, RData SHALL be set to 0.
REQ-023 Outside ACCESS, Mem_MemWrite and Mem_MemRead SHALL be 0, and Mem_Adresa/Mem_WriteData SHALL hold their last values.
REQ-024 Mem_MemWrite and Mem_MemRead SHALL never be high together.
REQ-025 Latency SHALL be: Req sampled in IDLE at edge N -> Ack high in cycle N+2 for a legal address, N+1 for an error.
REQ-026 A requester SHALL hold Req/Write/Addr/WData stable until Ack, since the block samples them only in IDLE.
REQ-027 A Req still high in the IDLE cycle after Ack SHALL be treated as a new transaction.
REQ-028 Req changes during ACCESS or RESP SHALL be ignored.
REQ-029 An ungranted port SHALL wait with no timeout; round-robin guarantees service within one transaction of the competing port.

Reset
REQ-030 With Reset=0 at a rising edge, the block SHALL force state IDLE, LastGrant=B (so A wins the first tie), and all Ack, Err, Mem strobes and Busy to 0.
REQ-031 Reset SHALL also clear A_RData, B_RData, Mem_Adresa and Mem_WriteData to 0.
REQ-032 Reset asserted mid-ACCESS SHALL abort the transaction with no Ack; a write whose strobe was already sampled by memory at that edge is not rolled back.

Verification
REQ-033 A write 0x3333 to address 0x0009, then A read 0x0009 -> Mem_MemWrite high for one cycle; A_Ack at N+2; read gives A_RData=0x3333, A_Err=0.
REQ-034 A and B request in the same cycle after reset -> A served first, B Ack follows; both again -> B served first.
REQ-035 B read at address 0x0100 (MEM_DEPTH=256) -> B_Ack and B_Err at N+1, B_RData=0, no memory strobe ever high.
REQ-036 A holds Req for 3 back-to-back reads while B waits -> A and B alternate grants; B completes no later than its second arbitration.
REQ-037 Reset pulled low during an A write ACCESS -> next cycle IDLE, A_Ack never asserted, all outputs 0.
REQ-038 Random-traffic check -> Mem_MemWrite and Mem_MemRead never high together; each Ack lasts exactly 1 cycle; Busy=0 only in IDLE.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Two-port round-robin arbiter in front of a single-ported DataMemory.
// Port A (CPU) and port B (DMA/debug) issue single-word read/write requests.
// A granted request is latched in IDLE. It then takes one of two paths:
//   - In-range address: ACCESS (one memory strobe cycle), then RESP.
//   - Out-of-range address: straight to RESP with Err=1 and no memory strobe.
// RESP pulses the granted port's Ack for one cycle before returning to IDLE.
//
// Ports
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_a_req/i_a_write          port A request and write(1)/read(0) select
//   i_a_addr/i_a_wdata         port A address and write data
//   o_a_ack/o_a_err/o_a_rdata  port A completion pulse, range error, read data
//   i_b_* / o_b_*              port B, identical to port A
//   o_mem_adresa               DataMemory address
//   o_mem_write_data           DataMemory write data
//   o_mem_mem_write            DataMemory write strobe
//   o_mem_mem_read             DataMemory read strobe
//   i_mem_read_data            DataMemory combinational read data
//   o_busy                     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_req,
    input  logic              i_a_write,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_ack,
    output logic              o_a_err,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_req,
    input  logic              i_b_write,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic              o_b_ack,
    output logic              o_b_err,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic [ADDR_W-1:0] o_mem_adresa,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_mem_write,
    output logic              o_mem_mem_read,
    input  logic [DATA_W-1:0] i_mem_read_data,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    state_t              r_state;
    logic                r_last_grant_b;   // 1: B won the most recent tie
    logic                r_grant_b;        // port owning the current transaction
    logic                r_a_ack;
    logic                r_a_err;
    logic [DATA_W-1:0]   r_a_rdata;
    logic                r_b_ack;
    logic                r_b_err;
    logic [DATA_W-1:0]   r_b_rdata;
    logic [ADDR_W-1:0]   r_mem_adresa;
    logic [DATA_W-1:0]   r_mem_write_data;
    logic                r_mem_mem_write;
    logic                r_mem_mem_read;
    logic                r_busy;

    logic                w_req_any;
    logic                w_tie;
    logic                w_grant_b;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_addr_err;

    // Grant selection and request mux used only while the FSM is in IDLE.
    always_comb begin
        w_req_any = i_a_req | i_b_req;
        w_tie     = i_a_req & i_b_req;
        // On a tie, serve the port that did not win the previous tie.
        if (w_tie) begin
            w_grant_b = ~r_last_grant_b;
        end else begin
            w_grant_b = i_b_req;
        end
        if (w_grant_b) begin
            w_sel_write = i_b_write;
            w_sel_addr  = i_b_addr;
            w_sel_wdata = i_b_wdata;
        end else begin
            w_sel_write = i_a_write;
            w_sel_addr  = i_a_addr;
            w_sel_wdata = i_a_wdata;
        end
        w_addr_err = ({1'b0, w_sel_addr} >= DEPTH_EXT);
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_last_grant_b   <= 1'b1;
            r_grant_b        <= 1'b0;
            r_a_ack          <= 1'b0;
            r_a_err          <= 1'b0;
            r_a_rdata        <= {DATA_W{1'b0}};
            r_b_ack          <= 1'b0;
            r_b_err          <= 1'b0;
            r_b_rdata        <= {DATA_W{1'b0}};
            r_mem_adresa     <= {ADDR_W{1'b0}};
            r_mem_write_data <= {DATA_W{1'b0}};
            r_mem_mem_write  <= 1'b0;
            r_mem_mem_read   <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_grant_b <= w_grant_b;
                        r_busy    <= 1'b1;
                        // Fairness history only changes when a tie was resolved.
                        if (w_tie) begin
                            r_last_grant_b <= w_grant_b;
                        end else begin
                            r_last_grant_b <= r_last_grant_b;
                        end
                        if (w_addr_err) begin
                            // Out of range: answer immediately, memory untouched.
                            r_state <= ST_RESP;
                            if (w_grant_b) begin
                                r_b_ack   <= 1'b1;
                                r_b_err   <= 1'b1;
                                r_b_rdata <= {DATA_W{1'b0}};
                            end else begin
                                r_a_ack   <= 1'b1;
                                r_a_err   <= 1'b1;
                                r_a_rdata <= {DATA_W{1'b0}};
                            end
                        end else begin
                            r_state          <= ST_ACCESS;
                            r_mem_adresa     <= w_sel_addr;
                            r_mem_write_data <= w_sel_wdata;
                            r_mem_mem_write  <= w_sel_write;
                            r_mem_mem_read   <= ~w_sel_write;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    // Strobe lasts exactly this cycle; read data is captured at its closing edge.
                    r_mem_mem_write <= 1'b0;
                    r_mem_mem_read  <= 1'b0;
                    r_state         <= ST_RESP;
                    if (r_grant_b) begin
                        r_b_ack   <= 1'b1;
                        r_b_rdata <= r_mem_mem_read ? i_mem_read_data : {DATA_W{1'b0}};
                    end else begin
                        r_a_ack   <= 1'b1;
                        r_a_rdata <= r_mem_mem_read ? i_mem_read_data : {DATA_W{1'b0}};
                    end
                end
                ST_RESP: begin
                    r_a_ack <= 1'b0;
                    r_a_err <= 1'b0;
                    r_b_ack <= 1'b0;
                    r_b_err <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_a_ack         <= 1'b0;
                    r_a_err         <= 1'b0;
                    r_b_ack         <= 1'b0;
                    r_b_err         <= 1'b0;
                    r_mem_mem_write <= 1'b0;
                    r_mem_mem_read  <= 1'b0;
                    r_busy          <= 1'b0;
                end
            endcase
        end
    end

    assign o_a_ack          = r_a_ack;
    assign o_a_err          = r_a_err;
    assign o_a_rdata        = r_a_rdata;
    assign o_b_ack          = r_b_ack;
    assign o_b_err          = r_b_err;
    assign o_b_rdata        = r_b_rdata;
    assign o_mem_adresa     = r_mem_adresa;
    assign o_mem_write_data = r_mem_write_data;
    assign o_mem_mem_write  = r_mem_mem_write;
    assign o_mem_mem_read   = r_mem_mem_read;
    assign o_busy           = r_busy;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
//
// Directed and random stimulus for data_memory_arbiter. The bench contains a
// behavioural DataMemory and a reference copy of its contents. Expected
// responses ({err, rdata}) are queued per port when a request is issued. A
// negedge monitor pops the queue on every Ack and also checks the cycle
// invariants.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_write, b_req, b_write;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        o_a_ack, o_a_err, o_b_ack, o_b_err;
    logic [15:0] o_a_rdata, o_b_rdata;
    logic [15:0] o_mem_adresa, o_mem_write_data, mem_rdata;
    logic        o_mem_mem_write, o_mem_mem_read, o_busy;

    int          total = 0;
    int          bad   = 0;
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    int          order_q[$];
    logic [15:0] mem[0:255];
    logic [15:0] ref_mem[0:255];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        prev_a_ack = 1'b0;
    logic        prev_b_ack = 1'b0;
    logic        mon_en = 1'b0;
    logic [16:0] mon_e;

    data_memory_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(256)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_a_req          (a_req),
        .i_a_write        (a_write),
        .i_a_addr         (a_addr),
        .i_a_wdata        (a_wdata),
        .o_a_ack          (o_a_ack),
        .o_a_err          (o_a_err),
        .o_a_rdata        (o_a_rdata),
        .i_b_req          (b_req),
        .i_b_write        (b_write),
        .i_b_addr         (b_addr),
        .i_b_wdata        (b_wdata),
        .o_b_ack          (o_b_ack),
        .o_b_err          (o_b_err),
        .o_b_rdata        (o_b_rdata),
        .o_mem_adresa     (o_mem_adresa),
        .o_mem_write_data (o_mem_write_data),
        .o_mem_mem_write  (o_mem_mem_write),
        .o_mem_mem_read   (o_mem_mem_read),
        .i_mem_read_data  (mem_rdata),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    // DataMemory model: combinational read, write on the rising edge.
    assign mem_rdata = o_mem_mem_read ? mem[o_mem_adresa[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (o_mem_mem_write) mem[o_mem_adresa[7:0]] = o_mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pops on Ack plus per-cycle invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_excl", 32'(o_mem_mem_write & o_mem_mem_read), 32'd0);
            check("busy_cover", 32'((o_a_ack | o_b_ack | o_mem_mem_write | o_mem_mem_read) & ~o_busy), 32'd0);
            check("a_ack_1cyc", 32'(o_a_ack & prev_a_ack), 32'd0);
            check("b_ack_1cyc", 32'(o_b_ack & prev_b_ack), 32'd0);
            check("a_err_noack", 32'(o_a_err & ~o_a_ack), 32'd0);
            check("b_err_noack", 32'(o_b_err & ~o_b_ack), 32'd0);
            if (o_mem_mem_write | o_mem_mem_read) check("mem_addr_range", 32'(o_mem_adresa[15:8]), 32'd0);
            if (o_mem_mem_write) wr_cnt++;
            if (o_mem_mem_read) rd_cnt++;
            if (o_a_ack) begin
                check("a_sb_nonempty", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) begin
                    mon_e = qa.pop_front();
                    check("a_err", 32'(o_a_err), 32'(mon_e[16]));
                    check("a_rdata", 32'(o_a_rdata), 32'(mon_e[15:0]));
                end
            end
            if (o_b_ack) begin
                check("b_sb_nonempty", 32'(qb.size() > 0), 32'd1);
                if (qb.size() > 0) begin
                    mon_e = qb.pop_front();
                    check("b_err", 32'(o_b_err), 32'(mon_e[16]));
                    check("b_rdata", 32'(o_b_rdata), 32'(mon_e[15:0]));
                end
            end
        end
        prev_a_ack = o_a_ack;
        prev_b_ack = o_b_ack;
    end

    task automatic expect_txn(input bit b, input bit wr, input logic [15:0] ad, input logic [15:0] wd);
        logic [16:0] e;
        if (ad >= 16'd256) begin
            e = {1'b1, 16'h0000};
        end else if (wr) begin
            e = {1'b0, 16'h0000};
            ref_mem[ad[7:0]] = wd;
        end else begin
            e = {1'b0, ref_mem[ad[7:0]]};
        end
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic set_port(input bit b, input bit req, input bit wr, input logic [15:0] ad, input logic [15:0] wd);
        if (b) begin
            b_req = req; b_write = wr; b_addr = ad; b_wdata = wd;
        end else begin
            a_req = req; a_write = wr; a_addr = ad; a_wdata = wd;
        end
    endtask

    // One isolated transaction with latency, Busy and strobe-count checks.
    task automatic single(input bit b, input bit wr, input logic [15:0] ad, input logic [15:0] wd, input string tag);
        int   lat = 0;
        int   w0 = wr_cnt;
        int   r0 = rd_cnt;
        logic got = 1'b0;
        bit   legal = (ad < 16'd256);
        expect_txn(b, wr, ad, wd);
        set_port(b, 1'b1, wr, ad, wd);
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = b ? o_b_ack : o_a_ack;
        end
        set_port(b, 1'b0, wr, ad, wd);
        check({tag, "_latency"}, 32'(lat), legal ? 32'd2 : 32'd1);
        check({tag, "_busy_resp"}, 32'(o_busy), 32'd1);
        @(negedge clk);
        check({tag, "_busy_idle"}, 32'(o_busy), 32'd0);
        check({tag, "_wr_strobes"}, 32'(wr_cnt - w0), (legal && wr) ? 32'd1 : 32'd0);
        check({tag, "_rd_strobes"}, 32'(rd_cnt - r0), (legal && !wr) ? 32'd1 : 32'd0);
    endtask

    // Wait until A and B have been acked na/nb times; each Req drops at its last Ack.
    task automatic run(input int na, input int nb, input string tag);
        int ca = 0;
        int cb = 0;
        int cyc = 0;
        int bound = 12 * (na + nb) + 8;
        order_q.delete();
        while ((ca < na || cb < nb) && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (o_a_ack) begin
                ca++;
                order_q.push_back(0);
                if (ca >= na) a_req = 1'b0;
            end
            if (o_b_ack) begin
                cb++;
                order_q.push_back(1);
                if (cb >= nb) b_req = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check({tag, "_a_count"}, 32'(ca), 32'(na));
        check({tag, "_b_count"}, 32'(cb), 32'(nb));
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ad;
        logic [15:0] wd;
        bit          wr, ua, ub;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 7 + 3);
            ref_mem[i] = 16'(i * 7 + 3);
        end
        rst_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check("rst_a_ack", 32'(o_a_ack), 32'd0);
        check("rst_a_err", 32'(o_a_err), 32'd0);
        check("rst_a_rdata", 32'(o_a_rdata), 32'd0);
        check("rst_b_ack", 32'(o_b_ack), 32'd0);
        check("rst_b_err", 32'(o_b_err), 32'd0);
        check("rst_b_rdata", 32'(o_b_rdata), 32'd0);
        check("rst_mem_addr", 32'(o_mem_adresa), 32'd0);
        check("rst_mem_wdata", 32'(o_mem_write_data), 32'd0);
        check("rst_mem_wr", 32'(o_mem_mem_write), 32'd0);
        check("rst_mem_rd", 32'(o_mem_mem_read), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Simultaneous requests after reset: A first.
        expect_txn(1'b0, 1'b1, 16'h0010, 16'h1111);
        expect_txn(1'b1, 1'b1, 16'h0050, 16'h5555);
        set_port(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1111);
        set_port(1'b1, 1'b1, 1'b1, 16'h0050, 16'h5555);
        run(1, 1, "tie1");
        check("tie1_first", 32'(order_q[0]), 32'd0);
        check("tie1_second", 32'(order_q[1]), 32'd1);

        // Second tie: B first.
        expect_txn(1'b0, 1'b0, 16'h0010, 16'h0000);
        expect_txn(1'b1, 1'b0, 16'h0050, 16'h0000);
        set_port(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        set_port(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0000);
        run(1, 1, "tie2");
        check("tie2_first", 32'(order_q[0]), 32'd1);
        check("tie2_second", 32'(order_q[1]), 32'd0);

        // Write then read back at 0x0009.
        single(1'b0, 1'b1, 16'h0009, 16'h3333, "a_wr9");
        single(1'b0, 1'b0, 16'h0009, 16'h0000, "a_rd9");
        check("a_rd9_rdata", 32'(o_a_rdata), 32'h3333);

        // Out-of-range B read; A's read data and memory address must hold.
        single(1'b1, 1'b0, 16'h0100, 16'h0000, "b_oor");
        check("b_oor_rdata_held", 32'(o_b_rdata), 32'd0);
        check("a_rdata_held", 32'(o_a_rdata), 32'h3333);
        check("mem_addr_held", 32'(o_mem_adresa), 32'h0009);

        // A holds Req for three reads while B waits: A,B,A,A.
        for (int i = 0; i < 3; i++) expect_txn(1'b0, 1'b0, 16'h0009, 16'h0000);
        expect_txn(1'b1, 1'b0, 16'h0010, 16'h0000);
        set_port(1'b0, 1'b1, 1'b0, 16'h0009, 16'h0000);
        set_port(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        run(3, 1, "hold");
        check("hold_o0", 32'(order_q[0]), 32'd0);
        check("hold_o1", 32'(order_q[1]), 32'd1);
        check("hold_o2", 32'(order_q[2]), 32'd0);
        check("hold_o3", 32'(order_q[3]), 32'd0);

        // Reset during an A write ACCESS: the memory already sampled the strobe, but no Ack follows.
        set_port(1'b0, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
        @(negedge clk);
        check("mid_wr_strobe", 32'(o_mem_mem_write), 32'd1);
        check("mid_busy", 32'(o_busy), 32'd1);
        ref_mem[8'h20] = 16'hBEEF;
        rst_n = 1'b0;
        a_req = 1'b0;
        @(negedge clk);
        check("mid_a_ack", 32'(o_a_ack), 32'd0);
        check("mid_busy_after", 32'(o_busy), 32'd0);
        check("mid_strobes", 32'({o_mem_mem_write, o_mem_mem_read}), 32'd0);
        check("mid_a_rdata", 32'(o_a_rdata), 32'd0);
        check("mid_mem_addr", 32'(o_mem_adresa), 32'd0);
        check("mid_mem_wdata", 32'(o_mem_write_data), 32'd0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mid_no_ack", 32'(o_a_ack), 32'd0);
        end

        // Random traffic: A uses 0..63, B uses 64..127, with some out-of-range addresses.
        for (int it = 0; it < 30; it++) begin
            ua = 1'($urandom_range(0, 1));
            ub = 1'($urandom_range(0, 1));
            if (!ua && !ub) ua = 1'b1;
            if (ua) begin
                ad = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 500)) : 16'($urandom_range(0, 63));
                wr = 1'($urandom_range(0, 1));
                wd = 16'($urandom);
                expect_txn(1'b0, wr, ad, wd);
                set_port(1'b0, 1'b1, wr, ad, wd);
            end
            if (ub) begin
                ad = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 500)) : 16'($urandom_range(64, 127));
                wr = 1'($urandom_range(0, 1));
                wd = 16'($urandom);
                expect_txn(1'b1, wr, ad, wd);
                set_port(1'b1, 1'b1, wr, ad, wd);
            end
            run(int'(ua), int'(ub), "rand");
        end

        check("sb_a_drained", 32'(qa.size()), 32'd0);
        check("sb_b_drained", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
